alu_issue_ctrl: RTL and testbench

Operand-issue and result-capture stage wrapped around `alu_top`. It sits directly upstream and downstream of the ALU. It buffers incoming operation requests in a small FIFO and presents the head entry to the ALU's `in_1`/`in_2`/`aluop` inputs. It then registers the combinational `alu_out` into a valid/ready response port. Optionally, operand 1 can be forwarded from the previous result so dependent operations chain back-to-back.

---
 rtl/alu_issue_ctrl.sv | 135 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Operand-issue FIFO and registered result capture around alu_top.
// Optional operand-1 forwarding from the last captured result: ALU_ISSUE_FWD_EN.
module alu_issue_ctrl #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int OP_W   = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [DATA_W-1:0]        req_in_1,
   input  logic [DATA_W-1:0]        req_in_2,
   input  logic [OP_W-1:0]          req_aluop,
   input  logic                     req_fwd_1,
   output logic [DATA_W-1:0]        alu_in_1,
   output logic [DATA_W-1:0]        alu_in_2,
   output logic [OP_W-1:0]          alu_aluop,
   input  logic [DATA_W-1:0]        alu_out,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DATA_W-1:0]        rsp_data,
   output logic                     rsp_err,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {EMPTY, FULL} out_state_t;

   logic [DATA_W-1:0] mem_in_1 [DEPTH];
   logic [DATA_W-1:0] mem_in_2 [DEPTH];
   logic [OP_W-1:0]   mem_op   [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   out_state_t        state, state_nxt;
   logic              push, capture, head_valid, head_illegal;
   logic [OP_W-1:0]   head_op;
   logic [DATA_W-1:0] result;

`ifdef ALU_ISSUE_FWD_EN
   logic              mem_fwd [DEPTH];
   logic [DATA_W-1:0] last_result;
`else
   logic              fwd_unused;
   assign fwd_unused = req_fwd_1;
`endif

   function automatic logic op_legal(input logic [OP_W-1:0] op);
      return (op == OP_W'(1)) || (op == OP_W'(2)) ||
             ((op >= OP_W'(5)) && (op <= OP_W'(16)));
   endfunction

   // Ready ignores a same-cycle pop, so a full FIFO never accepts.
   assign req_ready    = !rst && (count < CW'(DEPTH));
   assign push         = req_valid && req_ready;
   assign head_valid   = (count != '0);
   assign head_op      = mem_op[rd_ptr];
   assign head_illegal = !op_legal(head_op);
   assign capture      = head_valid && ((state == EMPTY) || rsp_ready);
   assign result       = head_illegal ? '0 : alu_out;
   assign rsp_valid    = (state == FULL);
   assign fifo_count   = count;

   always_comb begin
      alu_in_1  = '0;
      alu_in_2  = '0;
      alu_aluop = '0;
      if (head_valid) begin
         alu_in_1  = mem_in_1[rd_ptr];
`ifdef ALU_ISSUE_FWD_EN
         if (mem_fwd[rd_ptr]) alu_in_1 = last_result;
`endif
         alu_in_2  = mem_in_2[rd_ptr];
         alu_aluop = head_illegal ? '0 : head_op;
      end
   end

   always_comb begin
      state_nxt = state;
      if (capture)
         state_nxt = FULL;
      else if ((state == FULL) && rsp_ready)
         state_nxt = EMPTY;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_in_1[wr_ptr] <= req_in_1;
         mem_in_2[wr_ptr] <= req_in_2;
         mem_op[wr_ptr]   <= req_aluop;
`ifdef ALU_ISSUE_FWD_EN
         mem_fwd[wr_ptr]  <= req_fwd_1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)    wr_ptr <= wr_ptr + 1'b1;
         if (capture) rd_ptr <= rd_ptr + 1'b1;
         case ({push, capture})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= EMPTY;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
`ifdef ALU_ISSUE_FWD_EN
         last_result <= '0;
`endif
      end else begin
         state <= state_nxt;
         if (capture) begin
            rsp_data <= result;
            rsp_err  <= head_illegal;
`ifdef ALU_ISSUE_FWD_EN
            last_result <= result;
`endif
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU and request-level reference model.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_fwd_1;
   logic [31:0] req_in_1, req_in_2;
   logic [4:0]  req_aluop;
   logic [31:0] alu_in_1, alu_in_2, alu_out;
   logic [4:0]  alu_aluop;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_data;
   logic [2:0]  fifo_count;

   int unsigned errors = 0;
   int unsigned checks = 0;

   typedef struct {logic [31:0] data; logic err;} exp_t;
   exp_t        exp_q[$];
   logic [31:0] model_last = '0;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.DEPTH(4), .DATA_W(32), .OP_W(5)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_in_1(req_in_1), .req_in_2(req_in_2), .req_aluop(req_aluop), .req_fwd_1(req_fwd_1),
      .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_aluop(alu_aluop), .alu_out(alu_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .fifo_count(fifo_count)
   );

   function automatic logic is_legal(input logic [4:0] op);
      return (op == 5'd1) || (op == 5'd2) || (op >= 5'd5 && op <= 5'd16);
   endfunction

   // Stand-in for alu_top; op 0 deliberately yields a non-zero value.
   function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
      case (op)
         5'd1:    return a + b;
         5'd2:    return a - b;
         5'd5:    return a & b;
         5'd6:    return a | b;
         5'd7:    return a ^ b;
         5'd8:    return a << b[4:0];
         default: return a ^ (b + {27'd0, op}) ^ 32'h5a5a_0000;
      endcase
   endfunction

   always_comb alu_out = alu_fn(alu_in_1, alu_in_2, alu_aluop);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic model_push(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op, input logic f);
      logic [31:0] a1;
      exp_t e;
      a1 = a;
`ifdef ALU_ISSUE_FWD_EN
      if (f) a1 = model_last;
`endif
      e.err  = !is_legal(op);
      e.data = e.err ? 32'd0 : alu_fn(a1, b, op);
      model_last = e.data;
      exp_q.push_back(e);
   endtask

   // Called at posedge+1; returns at posedge+1 after the edge that would accept it.
   task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op, input logic f);
      req_valid = 1'b1; req_in_1 = a; req_in_2 = b; req_aluop = op; req_fwd_1 = f;
      @(negedge clk);
      if (req_ready && !rst) model_push(a, b, op, f);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_rsp_data"},  rsp_data, 32'd0);
      check({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
      check({tag, "_alu_in_1"},  alu_in_1, 32'd0);
      check({tag, "_alu_in_2"},  alu_in_2, 32'd0);
      check({tag, "_alu_aluop"}, 32'(alu_aluop), 32'd0);
      check({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
   endtask

   // Monitor: a handshake seen at the negedge completes on the following posedge.
   always @(negedge clk) begin
      if (!rst) begin
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected: got data %0h err %0b, expected no response", rsp_data, rsp_err);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("rsp_data", rsp_data, e.data);
               check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
         end
         if (fifo_count == 3'd0) begin
            check("empty_alu_in_1", alu_in_1, 32'd0);
            check("empty_alu_aluop", 32'(alu_aluop), 32'd0);
         end else if (!is_legal(alu_aluop)) begin
            check("alu_aluop_illegal", 32'(alu_aluop), 32'd0);
         end
      end
   end

   initial begin
      rst = 1'b1; req_valid = 1'b1; req_in_1 = 32'd3; req_in_2 = 32'd4;
      req_aluop = 5'd1; req_fwd_1 = 1'b0; rsp_ready = 1'b1;

      // Reset held with a pending request
      repeat (2) begin
         @(negedge clk);
         check("rst_req_ready", 32'(req_ready), 32'd0);
         check_idle_outputs("rst");
      end
      @(posedge clk); #1;
      rst = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      check("post_rst_req_ready", 32'(req_ready), 32'd1);
      check_idle_outputs("post_rst");
      next_cycle();

      // Single op
      push_op(32'd5, 32'd6, 5'd1, 1'b0);
      @(negedge clk);
      check("single_alu_in_1", alu_in_1, 32'd5);
      check("single_alu_in_2", alu_in_2, 32'd6);
      check("single_alu_aluop", 32'(alu_aluop), 32'd1);
      check("single_rsp_valid_early", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("single_rsp_valid", 32'(rsp_valid), 32'd1);
      next_cycle();
      next_cycle();

      // Backpressure: six pushes, one captured, four queued, one refused
      rsp_ready = 1'b0;
      push_op(32'd5, 32'd5, 5'd1, 1'b0);
      push_op(32'd5, 32'd5, 5'd2, 1'b0);
      push_op(32'd5, 32'd5, 5'd5, 1'b0);
      push_op(32'd5, 32'd5, 5'd6, 1'b0);
      push_op(32'd5, 32'd5, 5'd7, 1'b0);
      push_op(32'd5, 32'd5, 5'd8, 1'b0);
      check("bp_accepted", exp_q.size(), 32'd5);
      repeat (3) begin
         @(negedge clk);
         check("bp_fifo_count", 32'(fifo_count), 32'd4);
         check("bp_req_ready", 32'(req_ready), 32'd0);
         check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         check("bp_rsp_hold", rsp_data, exp_q[0].data);
         next_cycle();
      end
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("drain_rsp_valid", 32'(rsp_valid), 32'd1);
         next_cycle();
      end
      @(negedge clk);
      check("drain_done_rsp_valid", 32'(rsp_valid), 32'd0);
      next_cycle();

      // Illegal opcodes
      push_op(32'd9, 32'd4, 5'd3, 1'b0);
      @(negedge clk);
      check("illegal3_aluop", 32'(alu_aluop), 32'd0);
      next_cycle();
      push_op(32'd9, 32'd4, 5'd0, 1'b0);
      push_op(32'd9, 32'd4, 5'd2, 1'b0);
      repeat (3) next_cycle();

      // Forwarding back-to-back
      push_op(32'd5, 32'd6, 5'd1, 1'b0);
      push_op(32'd99, 32'd5, 5'd2, 1'b1);
      @(negedge clk);
`ifdef ALU_ISSUE_FWD_EN
      check("fwd_alu_in_1", alu_in_1, 32'd11);
`else
      check("fwd_alu_in_1", alu_in_1, 32'd99);
`endif
      repeat (3) next_cycle();

      // Mid-stream reset with results pending
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_op(32'(i + 20), 32'd1, 5'd1, 1'b0);
      @(negedge clk);
      check("mid_fifo_count", 32'(fifo_count), 32'd3);
      check("mid_rsp_valid", 32'(rsp_valid), 32'd1);
      next_cycle();
      rst = 1'b1;
      exp_q.delete();
      model_last = '0;
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("mid_rst");
      next_cycle();
      rsp_ready = 1'b1;
      repeat (4) next_cycle();
      push_op(32'd7, 32'd3, 5'd1, 1'b1);
      @(negedge clk);
`ifdef ALU_ISSUE_FWD_EN
      check("post_rst_fwd_alu_in_1", alu_in_1, 32'd0);
`else
      check("post_rst_fwd_alu_in_1", alu_in_1, 32'd7);
`endif
      next_cycle();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [4:0] op;
         rsp_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(0, 31));
         else op = 5'($urandom_range(5, 16));
         if ($urandom_range(0, 4) == 0) op = 5'($urandom_range(1, 2));
         if ($urandom_range(0, 2) != 0)
            push_op($urandom, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                    op, 1'($urandom_range(0, 1)));
         else
            next_cycle();
      end

      rsp_ready = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) next_cycle();
      next_cycle();
      check("final_queue_empty", exp_q.size(), 32'd0);
      check("final_fifo_count", 32'(fifo_count), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
